// File: rtl/cascade_counter.sv
`default_nettype none
// ============================================================================
// Module   : cascade_counter
// Purpose  : Cascaded BCD/hex up/down counter with load, clear, edge or level
//            count enable, per-digit terminal flags and a sticky wrap flag.
// Revision : 1.0  initial release
// ============================================================================
module cascade_counter #(
    parameter int DIGITS  = 4,
    parameter int RADIX   = 10,
    parameter int EDGE_CE = 1
) (
    input  logic                  clk,
    input  logic                  r,
    input  logic                  ce,
    input  logic                  clr,
    input  logic                  up,
    input  logic                  l,
    input  logic [4*DIGITS-1:0]   di,
    output logic [4*DIGITS-1:0]   q,
    output logic                  tc,
    output logic                  ceo,
    output logic [DIGITS-1:0]     dtc,
    output logic                  ovf
);

    localparam int         c_w    = 4 * DIGITS;
    localparam logic [3:0] c_max  = 4'(RADIX - 1);
    localparam logic       c_edge = (EDGE_CE != 0);

    logic [c_w-1:0]    r_q;
    logic              r_ovf;
    logic              r_ce_d;
    logic              w_evt;
    logic [c_w-1:0]    w_nxt;
    logic [DIGITS-1:0] w_dtc;
    logic [DIGITS:0]   w_chain;
    logic [3:0]        w_d;
    logic [3:0]        w_ld;
    logic [3:0]        w_st;

    // In level mode the previous-cycle enable is ignored, so every high cycle counts.
    assign w_evt = ce & (c_edge ? ~r_ce_d : 1'b1);

    always_comb begin
        w_nxt      = r_q;
        w_dtc      = '0;
        w_chain    = '0;
        w_chain[0] = 1'b1;
        w_d        = 4'd0;
        w_ld       = 4'd0;
        w_st       = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            w_d            = r_q[4*k +: 4];
            w_dtc[k]       = up ? (w_d == c_max) : (w_d == 4'd0);
            w_chain[k+1]   = w_chain[k] & w_dtc[k];
            w_ld           = (di[4*k +: 4] > c_max) ? c_max : di[4*k +: 4];
            if (up)
                w_st = (w_d == c_max) ? 4'd0 : w_d + 4'd1;
            else
                w_st = (w_d == 4'd0) ? c_max : w_d - 4'd1;
            // A digit steps only when every lower digit sits at its terminal value.
            if (clr)
                w_nxt[4*k +: 4] = 4'd0;
            else if (l)
                w_nxt[4*k +: 4] = w_ld;
            else if (w_evt && w_chain[k])
                w_nxt[4*k +: 4] = w_st;
            else
                w_nxt[4*k +: 4] = w_d;
        end
    end

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            r_q    <= '0;
            r_ovf  <= 1'b0;
            r_ce_d <= 1'b0;
        end else begin
            r_ce_d <= ce;
            r_q    <= w_nxt;
            if (clr)
                r_ovf <= 1'b0;
            else if (ceo)
                r_ovf <= 1'b1;
        end
    end

    assign q   = r_q;
    assign dtc = w_dtc;
    assign tc  = w_chain[DIGITS];
    assign ceo = w_evt & tc & ~clr & ~l;
    assign ovf = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_cascade_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cascade_counter
// Purpose  : Self-checking bench for cascade_counter (BCD/edge and hex/level
//            instances) against an integer-valued reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_cascade_counter;

    logic        clk = 1'b0;
    logic        r;
    logic        ce, clr, up, l;
    logic [15:0] di, q;
    logic        tc, ceo, ovf;
    logic [3:0]  dtc;
    logic        ce2, clr2, up2, l2;
    logic [7:0]  di2, q2;
    logic        tc2, ceo2, ovf2;
    logic [1:0]  dtc2;

    int total = 0;
    int bad   = 0;
    int mv1, mv2, ceo2_cnt;
    bit mcd1, movf1, movf2;

    always #5 clk = ~clk;

    cascade_counter #(.DIGITS(4), .RADIX(10), .EDGE_CE(1)) u_bcd (
        .clk(clk), .r(r), .ce(ce), .clr(clr), .up(up), .l(l), .di(di),
        .q(q), .tc(tc), .ceo(ceo), .dtc(dtc), .ovf(ovf)
    );

    cascade_counter #(.DIGITS(2), .RADIX(16), .EDGE_CE(0)) u_hex (
        .clk(clk), .r(r), .ce(ce2), .clr(clr2), .up(up2), .l(l2), .di(di2),
        .q(q2), .tc(tc2), .ceo(ceo2), .dtc(dtc2), .ovf(ovf2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int modulus(input int rad, input int nd);
        int m = 1;
        for (int k = 0; k < nd; k++) m = m * rad;
        return m;
    endfunction

    // Integer value of a digit vector, with out-of-range digits saturated.
    function automatic int to_val(input logic [31:0] v, input int rad, input int nd);
        int a = 0;
        int d;
        for (int k = nd - 1; k >= 0; k--) begin
            d = int'(v[4*k +: 4]);
            if (d > rad - 1) d = rad - 1;
            a = a * rad + d;
        end
        return a;
    endfunction

    function automatic logic [31:0] to_vec(input int v, input int rad, input int nd);
        logic [31:0] o = '0;
        for (int k = 0; k < nd; k++) begin
            o[4*k +: 4] = 4'(v % rad);
            v = v / rad;
        end
        return o;
    endfunction

    function automatic logic [31:0] exp_dtc(input int v, input bit u, input int rad, input int nd);
        logic [31:0] o = '0;
        for (int k = 0; k < nd; k++) begin
            o[k] = u ? ((v % rad) == rad - 1) : ((v % rad) == 0);
            v = v / rad;
        end
        return o;
    endfunction

    function automatic int next_val(input int v, input bit c, input bit ld, input bit ev,
                                    input bit u, input logic [31:0] d, input int rad, input int nd);
        int m = modulus(rad, nd);
        if (c)  return 0;
        if (ld) return to_val(d, rad, nd);
        if (ev) return u ? (v + 1) % m : (v + m - 1) % m;
        return v;
    endfunction

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic tick();
        bit ev1, ev2, tcx1, tcx2, cx1, cx2;
        #1;
        ev1  = ce & ~mcd1;
        ev2  = ce2;
        tcx1 = up  ? (mv1 == 9999) : (mv1 == 0);
        tcx2 = up2 ? (mv2 == 255)  : (mv2 == 0);
        cx1  = ev1 & tcx1 & ~clr  & ~l;
        cx2  = ev2 & tcx2 & ~clr2 & ~l2;
        check("q",    32'(q),    to_vec(mv1, 10, 4));
        check("tc",   32'(tc),   32'(tcx1));
        check("ceo",  32'(ceo),  32'(cx1));
        check("dtc",  32'(dtc),  exp_dtc(mv1, up, 10, 4));
        check("ovf",  32'(ovf),  32'(movf1));
        check("q2",   32'(q2),   to_vec(mv2, 16, 2));
        check("tc2",  32'(tc2),  32'(tcx2));
        check("ceo2", 32'(ceo2), 32'(cx2));
        check("dtc2", 32'(dtc2), exp_dtc(mv2, up2, 16, 2));
        check("ovf2", 32'(ovf2), 32'(movf2));
        if (ceo2) ceo2_cnt++;
        @(posedge clk);
        if (clr) movf1 = 1'b0; else if (cx1) movf1 = 1'b1;
        if (clr2) movf2 = 1'b0; else if (cx2) movf2 = 1'b1;
        mv1  = next_val(mv1, clr, l, ev1, up, 32'(di), 10, 4);
        mv2  = next_val(mv2, clr2, l2, ev2, up2, 32'(di2), 16, 2);
        mcd1 = ce;
        @(negedge clk);
    endtask

    // Reset rises between clock edges and is held across one rising edge.
    task automatic do_reset();
        #2;
        r = 1'b1;
        #1;
        mv1 = 0; mv2 = 0; mcd1 = 1'b0; movf1 = 1'b0; movf2 = 1'b0;
        check("rst_q",   32'(q),   32'h0);
        check("rst_ovf", 32'(ovf), 32'h0);
        check("rst_q2",  32'(q2),  32'h0);
        @(negedge clk);
        r = 1'b0;
    endtask

    task automatic pulse();
        ce = 1'b1; tick();
        ce = 1'b0; tick();
    endtask

    initial begin
        r = 1'b1;
        ce = 0; clr = 0; up = 1; l = 0; di = '0;
        ce2 = 0; clr2 = 0; up2 = 1; l2 = 0; di2 = '0;
        ceo2_cnt = 0;
        @(negedge clk);
        do_reset();

        repeat (10) pulse();
        check("ten_q",   32'(q),   32'h0010);
        check("ten_dtc", 32'(dtc), 32'h0);
        check("ten_ovf", 32'(ovf), 32'h0);

        l = 1; di = 16'h9999; tick(); l = 0;
        ce = 1; #1 check("wrap_ceo", 32'(ceo), 32'h1);
        tick(); ce = 0; tick();
        check("wrap_q",   32'(q),   32'h0000);
        check("wrap_ovf", 32'(ovf), 32'h1);
        clr = 1; tick(); clr = 0;
        check("clr_ovf", 32'(ovf), 32'h0);

        do_reset();
        up = 0;
        ce = 1; #1 check("bor_ceo", 32'(ceo), 32'h1);
        tick(); ce = 0; tick();
        check("bor_q", 32'(q), 32'h9999);
        ce = 1; repeat (20) tick(); ce = 0;
        check("held_q", 32'(q), 32'h9998);

        l = 1; di = 16'hFAC3; tick(); l = 0;
        check("clamp_q", 32'(q), 32'h9993);
        l = 1; ce = 1; di = 16'h1234; tick(); l = 0; ce = 0;
        check("ld_win_q", 32'(q), 32'h1234);
        tick();

        do_reset();
        ceo2_cnt = 0; up2 = 1; ce2 = 1;
        repeat (256) tick();
        ce2 = 0;
        check("hex_q",   32'(q2),     32'h00);
        check("hex_ceo", 32'(ceo2_cnt), 32'd1);
        check("hex_ovf", 32'(ovf2),   32'h1);

        up = 1; repeat (3) pulse();
        ce = 1; l = 1; clr = 1; di = 16'h5555;
        do_reset();
        ce = 0; l = 0; clr = 0;
        check("ovr_q", 32'(q), 32'h0);
        pulse();
        check("resume_q", 32'(q), 32'h0001);

        repeat (600) begin
            ce   = 1'($urandom_range(0, 1));
            clr  = ($urandom_range(0, 15) == 0);
            l    = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) up = ~up;
            di   = 16'($urandom);
            ce2  = ($urandom_range(0, 3) != 0);
            clr2 = ($urandom_range(0, 31) == 0);
            l2   = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 15) == 0) up2 = ~up2;
            di2  = 8'($urandom);
            if ($urandom_range(0, 99) == 0)
                do_reset();
            else
                tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cascade_counter.md
CASCADE_COUNTER -- requirements
Module: cascade_counter

Interface
REQ-001 Parameter DIGITS, default 4, meaning number of cascaded 4-bit digits (1..8).
REQ-002 Parameter RADIX, default 10, meaning digit modulus; legal values are 10 (BCD) and 16 (hex).
REQ-003 Parameter EDGE_CE, default 1, meaning 1 = count on ce rising edge, 0 = count on every cycle ce is high.
REQ-004 Clocking SHALL be one clock; reset SHALL be asynchronous and active-high.
REQ-005 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 Port r  input  1  asynchronous active-high reset.
REQ-007 Port ce  input  1  count enable / count strobe.
REQ-008 Port clr  input  1  synchronous clear.
REQ-009 Port up  input  1  direction, 1 = up, 0 = down.
REQ-010 Port l  input  1  synchronous parallel load.
REQ-011 Port di  input  4*DIGITS  load data, digit k at [4k+3:4k].
REQ-012 Port q  output  4*DIGITS  counter value, digit k at [4k+3:4k].
REQ-013 Port tc  output  1  terminal count for current direction.
REQ-014 Port ceo  output  1  carry/borrow out, one cycle per wrap.
REQ-015 Port dtc  output  DIGITS  per-digit terminal flags.
REQ-016 Port ovf  output  1  sticky wrap flag.

Function
REQ-017 Count event (evt) SHALL be ce & ~ce_d when EDGE_CE=1, with ce_d a register holding the previous-cycle ce, and SHALL be ce when EDGE_CE=0.
REQ-018 Control priority on each clock edge SHALL be: r > clr > l > evt > hold.
REQ-019 clr SHALL set all digits to 0 and clear ovf; ce_d SHALL still sample ce.
REQ-020 l SHALL load each digit from di; any loaded digit value >= RADIX SHALL be clamped to RADIX-1.
REQ-021 dtc[k] SHALL be 1 when digit k equals RADIX-1 (up=1) or 0 (up=0), combinationally from q and up.
REQ-022 On evt, digit 0 SHALL step by ±1; digit k>0 SHALL step only when dtc[k-1:0] are all 1.
REQ-023 A stepping digit at RADIX-1 going up SHALL wrap to 0; a stepping digit at 0 going down SHALL wrap to RADIX-1.
REQ-024 tc SHALL be the AND of all dtc bits, combinational.
REQ-025 ceo SHALL be evt & tc & ~clr & ~l, combinational, and high in the cycle whose edge wraps the whole counter.
REQ-026 ovf SHALL set on the edge where ceo is high and hold until r or clr.
REQ-027 A change of up between events SHALL take effect on the next evt with no extra step.
REQ-028 q SHALL update on the same edge that samples evt (latency 1 clk from ce assertion).
REQ-029 A held-high ce with EDGE_CE=1 SHALL produce exactly one step.
REQ-030 Digit values never SHALL leave 0..RADIX-1 under any input sequence after reset.

Reset
REQ-031 On r high, asynchronously: q = 0, ovf = 0, ce_d = 0; tc/dtc/ceo SHALL follow from q=0 and up.
REQ-032 Deassertion of r mid-operation SHALL resume counting from 0 on the first evt after release.
REQ-033 r SHALL override a simultaneous clr, l or evt.

Verification (DIGITS=4, RADIX=10, EDGE_CE=1 unless stated)
REQ-034 Pulse r, up=1, ten ce pulses -> q=0x0010, dtc=0000 after the last pulse, ovf=0.
REQ-035 l with di=0x9999, up=1, one ce pulse -> ceo high one cycle, q=0x0000, ovf=1; then clr -> ovf=0.
REQ-036 After r, up=0, one ce pulse -> q=0x9999, ceo high; ce held high 20 cycles -> exactly one further step, q=0x9998.
REQ-037 l with di=0xFAC3 -> q=0x9993; l and evt in the same cycle -> load wins, q=di-clamped.
REQ-038 RADIX=16, EDGE_CE=0, DIGITS=2, ce high 256 cycles from 0x00 -> q back to 0x00, ceo exactly once, ovf=1.
REQ-039 Assert r asynchronously between clock edges during counting -> q=0 immediately, without waiting for a clk edge.
